// File: rtl/enc_pkg.sv
// Shared widths, index type and multi-hot detection for the 4-to-1 encoder.
// Build option ENC_PRIORITY_EN (used by encoder_4to1_comb) selects highest-bit-wins encoding.
package enc_pkg;

    localparam int unsigned ENC_IN_W  = 4;
    localparam int unsigned ENC_OUT_W = 2;

    typedef logic [ENC_OUT_W-1:0] enc_idx_t;

    // True when any two request bits are set together.
    function automatic logic popcount_ge2(input logic [ENC_IN_W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(ENC_IN_W); i++) begin
            for (int j = i + 1; j < int'(ENC_IN_W); j++) begin
                r = r | (v[i] & v[j]);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/encoder_4to1_comb.sv
// Pure combinational 4-to-2 encode with valid and multi-hot flags.
// ENC_PRIORITY_EN defined: highest set bit wins; undefined: OR of the set-bit codes.
module encoder_4to1_comb
    import enc_pkg::*;
(
    input  logic [ENC_IN_W-1:0] x,
    output enc_idx_t            y_c,
    output logic                valid_c,
    output logic                multi_c
);

    always_comb begin
        y_c = enc_idx_t'(0);
`ifdef ENC_PRIORITY_EN
        if (x[3]) begin
            y_c = enc_idx_t'(3);
        end else if (x[2]) begin
            y_c = enc_idx_t'(2);
        end else if (x[1]) begin
            y_c = enc_idx_t'(1);
        end else begin
            y_c = enc_idx_t'(0);
        end
`else
        y_c = {x[3] | x[2], x[3] | x[1]};
`endif
    end

    assign valid_c = |x;
    assign multi_c = popcount_ge2(x);

endmodule

// File: rtl/encoder_4to1_reg.sv
// One-hot to binary encoder with optional output register and sticky multi-hot error latch.
// Encoding style follows ENC_PRIORITY_EN (see encoder_4to1_comb).
module encoder_4to1_reg
    import enc_pkg::*;
#(
    parameter bit REG_OUT   = 1'b1,
    parameter bit ZERO_HOLD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ENC_IN_W-1:0]  x,
    input  logic                 err_clr,
    output logic [ENC_OUT_W-1:0] y,
    output logic                 valid,
    output logic                 multi,
    output logic                 err_sticky
);

    enc_idx_t y_c;
    logic     valid_c;
    logic     multi_c;

    encoder_4to1_comb u_comb (
        .x       (x),
        .y_c     (y_c),
        .valid_c (valid_c),
        .multi_c (multi_c)
    );

    generate
        if (REG_OUT) begin : g_reg
            enc_idx_t y_q;
            logic     valid_q;
            logic     multi_q;

            // Idle input may keep the last index for consumers that need it stable.
            always_ff @(posedge clk) begin
                if (rst) begin
                    y_q     <= enc_idx_t'(0);
                    valid_q <= 1'b0;
                    multi_q <= 1'b0;
                end else begin
                    valid_q <= valid_c;
                    multi_q <= multi_c;
                    if (!(ZERO_HOLD && !valid_c)) begin
                        y_q <= y_c;
                    end
                end
            end

            assign y     = y_q;
            assign valid = valid_q;
            assign multi = multi_q;
        end else begin : g_comb
            assign y     = y_c;
            assign valid = valid_c;
            assign multi = multi_c;
        end
    endgenerate

    // A new multi-hot on the clearing edge re-arms the latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else begin
            err_sticky <= (err_sticky & ~err_clr) | multi_c;
        end
    end

endmodule

// File: tb/tb_encoder_4to1_reg.sv
// Directed table-driven bench for encoder_4to1_reg in registered, combinational and zero-hold setups.
module tb_encoder_4to1_reg;

    typedef struct {
        logic [3:0] x;
        logic [1:0] y_or;
        logic [1:0] y_pri;
        logic       valid;
        logic       multi;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] x;
    logic       err_clr;

    logic [1:0] y_r, y_c, y_h;
    logic       valid_r, valid_c, valid_h;
    logic       multi_r, multi_c, multi_h;
    logic       err_r, err_c, err_h;

    int checks = 0;
    int errors = 0;

    vec_t vecs [16];

    always #5 clk = ~clk;

    encoder_4to1_reg #(.REG_OUT(1'b1), .ZERO_HOLD(1'b0)) dut (
        .clk(clk), .rst(rst), .x(x), .err_clr(err_clr),
        .y(y_r), .valid(valid_r), .multi(multi_r), .err_sticky(err_r)
    );

    encoder_4to1_reg #(.REG_OUT(1'b0), .ZERO_HOLD(1'b0)) dut_comb (
        .clk(clk), .rst(rst), .x(x), .err_clr(err_clr),
        .y(y_c), .valid(valid_c), .multi(multi_c), .err_sticky(err_c)
    );

    encoder_4to1_reg #(.REG_OUT(1'b1), .ZERO_HOLD(1'b1)) dut_hold (
        .clk(clk), .rst(rst), .x(x), .err_clr(err_clr),
        .y(y_h), .valid(valid_h), .multi(multi_h), .err_sticky(err_h)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, then wait for the sampling edge plus a little.
    task automatic drive_and_clock(input logic r, input logic [3:0] xv, input logic clr);
        @(negedge clk);
        rst     = r;
        x       = xv;
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_y(input vec_t v);
`ifdef ENC_PRIORITY_EN
        return v.y_pri;
`else
        return v.y_or;
`endif
    endfunction

    initial begin
        logic       sticky_exp;
        logic [1:0] hold_exp;
        logic [1:0] ey;

        //         x        y_or   y_pri  valid multi
        vecs[0]  = '{4'b0000, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0001, 2'd0, 2'd0, 1'b1, 1'b0};
        vecs[2]  = '{4'b0010, 2'd1, 2'd1, 1'b1, 1'b0};
        vecs[3]  = '{4'b0011, 2'd1, 2'd1, 1'b1, 1'b1};
        vecs[4]  = '{4'b0100, 2'd2, 2'd2, 1'b1, 1'b0};
        vecs[5]  = '{4'b0101, 2'd2, 2'd2, 1'b1, 1'b1};
        vecs[6]  = '{4'b0110, 2'd3, 2'd2, 1'b1, 1'b1};
        vecs[7]  = '{4'b0111, 2'd3, 2'd2, 1'b1, 1'b1};
        vecs[8]  = '{4'b1000, 2'd3, 2'd3, 1'b1, 1'b0};
        vecs[9]  = '{4'b1001, 2'd3, 2'd3, 1'b1, 1'b1};
        vecs[10] = '{4'b1010, 2'd3, 2'd3, 1'b1, 1'b1};
        vecs[11] = '{4'b1011, 2'd3, 2'd3, 1'b1, 1'b1};
        vecs[12] = '{4'b1100, 2'd3, 2'd3, 1'b1, 1'b1};
        vecs[13] = '{4'b1101, 2'd3, 2'd3, 1'b1, 1'b1};
        vecs[14] = '{4'b1110, 2'd3, 2'd3, 1'b1, 1'b1};
        vecs[15] = '{4'b1111, 2'd3, 2'd3, 1'b1, 1'b1};

        rst = 1'b1; x = 4'b1111; err_clr = 1'b0;

        // Reset with multi-hot input: registered outputs zero, combinational copy unaffected.
        drive_and_clock(1'b1, 4'b1111, 1'b0);
        drive_and_clock(1'b1, 4'b1111, 1'b0);
        check("rst_y", 4'(y_r), 4'd0);
        check("rst_valid", 4'(valid_r), 4'd0);
        check("rst_multi", 4'(multi_r), 4'd0);
        check("rst_err", 4'(err_r), 4'd0);
        check("rst_hold_y", 4'(y_h), 4'd0);
        check("comb_in_rst_y", 4'(y_c), 4'd3);
        check("comb_in_rst_multi", 4'(multi_c), 4'd1);

        sticky_exp = 1'b0;
        hold_exp   = 2'd0;

        // One-hot sweep, then all 16 codes.
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 16; k++) begin
                int i;
                i = (pass == 0) ? (1 << (k % 4)) : k;
                if (pass == 0 && k >= 4) break;
                ey = exp_y(vecs[i]);
                @(negedge clk);
                rst = 1'b0; x = vecs[i].x; err_clr = 1'b0;
                #1;
                check("comb_y", 4'(y_c), 4'(ey));
                check("comb_valid", 4'(valid_c), 4'(vecs[i].valid));
                check("comb_multi", 4'(multi_c), 4'(vecs[i].multi));
                @(posedge clk);
                #1;
                sticky_exp = sticky_exp | vecs[i].multi;
                if (vecs[i].valid) hold_exp = ey;
                check("reg_y", 4'(y_r), 4'(ey));
                check("reg_valid", 4'(valid_r), 4'(vecs[i].valid));
                check("reg_multi", 4'(multi_r), 4'(vecs[i].multi));
                check("reg_err", 4'(err_r), 4'(sticky_exp));
                check("hold_y", 4'(y_h), 4'(hold_exp));
                check("hold_valid", 4'(valid_h), 4'(vecs[i].valid));
            end
        end

        // Sticky latch: clear, set, hold, clear, then set beats clear.
        drive_and_clock(1'b0, 4'b0001, 1'b1);
        check("stk_clear0", 4'(err_r), 4'd0);
        drive_and_clock(1'b0, 4'b0011, 1'b0);
        check("stk_set", 4'(err_r), 4'd1);
        check("stk_set_comb_inst", 4'(err_c), 4'd1);
        drive_and_clock(1'b0, 4'b0001, 1'b0);
        check("stk_hold", 4'(err_r), 4'd1);
        drive_and_clock(1'b0, 4'b0001, 1'b1);
        check("stk_clear", 4'(err_r), 4'd0);
        drive_and_clock(1'b0, 4'b1100, 1'b1);
        check("stk_set_wins", 4'(err_r), 4'd1);

        // Zero-hold: index 3 survives an idle cycle only in the hold instance.
        drive_and_clock(1'b0, 4'b1000, 1'b0);
        check("zh_y3", 4'(y_h), 4'd3);
        drive_and_clock(1'b0, 4'b0000, 1'b0);
        check("zh_hold_y", 4'(y_h), 4'd3);
        check("zh_hold_valid", 4'(valid_h), 4'd0);
        check("zh_plain_y", 4'(y_r), 4'd0);

        // Mid-operation reset then resume.
        drive_and_clock(1'b0, 4'b0100, 1'b0);
        check("pre_rst_y", 4'(y_r), 4'd2);
        drive_and_clock(1'b1, 4'b0110, 1'b0);
        check("mid_rst_y", 4'(y_r), 4'd0);
        check("mid_rst_valid", 4'(valid_r), 4'd0);
        check("mid_rst_multi", 4'(multi_r), 4'd0);
        check("mid_rst_err", 4'(err_r), 4'd0);
        check("mid_rst_hold_y", 4'(y_h), 4'd0);
        check("comb_mid_rst_y", 4'(y_c), 4'(exp_y(vecs[6])));
        drive_and_clock(1'b0, 4'b0010, 1'b0);
        check("resume_y", 4'(y_r), 4'd1);
        check("resume_valid", 4'(valid_r), 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
